// File: rtl/mem_pkg.sv
// Shared widths, FSM state encoding and requester IDs for the memory arbiter.
// Round-robin arbitration is enabled by defining MEMARB_RR_EN.
package mem_pkg;
  localparam int ADR_W  = 30;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, ACK = 2'd2} state_t;

  typedef logic [1:0] req_id_t;
  localparam req_id_t REQ_I = 2'd0;
  localparam req_id_t REQ_D = 2'd1;
  localparam req_id_t REQ_W = 2'd2;

  // Successor in the i -> d -> w rotation.
  function automatic req_id_t rr_next(input req_id_t id);
    case (id)
      REQ_I:   rr_next = REQ_D;
      REQ_D:   rr_next = REQ_W;
      default: rr_next = REQ_I;
    endcase
  endfunction

  // First active requester in the given order; en[0] pairs with a.
  function automatic req_id_t first_of(input logic [2:0] en,
                                       input req_id_t a, input req_id_t b, input req_id_t c);
    if (en[0])      first_of = a;
    else if (en[1]) first_of = b;
    else            first_of = c;
  endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: fixed d > i > w, or round-robin with MEMARB_RR_EN.
// The read-after-write hazard override always wins.
module mem_arb_pick
  import mem_pkg::*;
(
`ifdef MEMARB_RR_EN
  input  logic             clk,
  input  logic             reset,
  input  logic             upd,
`endif
  input  logic             i_en,
  input  logic             d_en,
  input  logic             d_rwb,
  input  logic             w_en,
  input  logic [ADR_W-1:0] d_adr,
  input  logic [ADR_W-1:0] w_adr,
  output req_id_t          win
);
  logic hazard;

`ifdef MEMARB_RR_EN
  // ptr holds the highest-priority requester for the next arbitration.
  req_id_t ptr;
  req_id_t rr;

  always_comb begin
    hazard = w_en & d_en & d_rwb & (d_adr == w_adr);
    case (ptr)
      REQ_I:   rr = first_of({w_en, d_en, i_en}, REQ_I, REQ_D, REQ_W);
      REQ_D:   rr = first_of({i_en, w_en, d_en}, REQ_D, REQ_W, REQ_I);
      default: rr = first_of({d_en, i_en, w_en}, REQ_W, REQ_I, REQ_D);
    endcase
    win = hazard ? REQ_W : rr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   ptr <= REQ_I;
    else if (upd) ptr <= rr_next(win);
  end
`else
  always_comb begin
    hazard = w_en & d_en & d_rwb & (d_adr == w_adr);
    if (hazard)    win = REQ_W;
    else if (d_en) win = REQ_D;
    else if (i_en) win = REQ_I;
    else           win = REQ_W;
  end
`endif
endmodule

// File: rtl/mem_arbiter.sv
// Three-requester memory arbiter (icache, dcache, write buffer): IDLE/MEM/ACK FSM
// with registered memory-side outputs. MEMARB_RR_EN selects round-robin arbitration.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADR_W-1:0]  i_adr,
  input  logic              i_en,
  output logic              i_done,
  input  logic [ADR_W-1:0]  d_adr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_byteen,
  input  logic              d_rwb,
  input  logic              d_en,
  output logic              d_done,
  input  logic [ADR_W-1:0]  w_adr,
  input  logic [DATA_W-1:0] w_wdata,
  input  logic [BE_W-1:0]   w_byteen,
  input  logic              w_en,
  output logic              w_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADR_W-1:0]  memadr,
  output logic [DATA_W-1:0] memwdata,
  input  logic [DATA_W-1:0] memrdata,
  output logic [BE_W-1:0]   membyteen,
  output logic              memrwb,
  output logic              memen,
  input  logic              memdone
);
  state_t  state;
  req_id_t gnt;
  req_id_t win;
  logic    any_en;

  assign any_en = i_en | d_en | w_en;

  mem_arb_pick u_pick (
`ifdef MEMARB_RR_EN
    .clk   (clk),
    .reset (reset),
    .upd   ((state == IDLE) & any_en),
`endif
    .i_en  (i_en),
    .d_en  (d_en),
    .d_rwb (d_rwb),
    .w_en  (w_en),
    .d_adr (d_adr),
    .w_adr (w_adr),
    .win   (win)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gnt       <= REQ_I;
      memen     <= 1'b0;
      memrwb    <= 1'b0;
      membyteen <= '0;
      memadr    <= '0;
      memwdata  <= '0;
      rdata     <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      w_done <= 1'b0;
      case (state)
        IDLE: if (any_en) begin
          state <= MEM;
          memen <= 1'b1;
          gnt   <= win;
          case (win)
            REQ_I: begin
              memadr    <= i_adr;
              memwdata  <= '0;
              membyteen <= '1;
              memrwb    <= 1'b1;
            end
            REQ_D: begin
              memadr    <= d_adr;
              memwdata  <= d_wdata;
              membyteen <= d_byteen;
              memrwb    <= d_rwb;
            end
            default: begin
              memadr    <= w_adr;
              memwdata  <= w_wdata;
              membyteen <= w_byteen;
              memrwb    <= 1'b0;
            end
          endcase
        end
        MEM: if (memdone) begin
          state <= ACK;
          memen <= 1'b0;
          if (memrwb) rdata <= memrdata;
          case (gnt)
            REQ_I:   i_done <= 1'b1;
            REQ_D:   d_done <= 1'b1;
            default: w_done <= 1'b1;
          endcase
        end
        // ACK is the mandatory gap cycle; done drops here.
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations cover both arbitration modes.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] i_adr, d_adr, w_adr, memadr;
  logic        i_en, d_en, d_rwb, w_en;
  logic        i_done, d_done, w_done;
  logic [31:0] d_wdata, w_wdata, rdata, memwdata, memrdata;
  logic [3:0]  d_byteen, w_byteen, membyteen;
  logic        memrwb, memen, memdone;

  int npass = 0;
  int ntotal = 0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_adr(i_adr), .i_en(i_en), .i_done(i_done),
    .d_adr(d_adr), .d_wdata(d_wdata), .d_byteen(d_byteen), .d_rwb(d_rwb),
    .d_en(d_en), .d_done(d_done),
    .w_adr(w_adr), .w_wdata(w_wdata), .w_byteen(w_byteen), .w_en(w_en),
    .w_done(w_done),
    .rdata(rdata), .memadr(memadr), .memwdata(memwdata), .memrdata(memrdata),
    .membyteen(membyteen), .memrwb(memrwb), .memen(memen), .memdone(memdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_dones(input string tag, input logic [2:0] exp_iwd);
    chk(tag, {29'd0, i_done, d_done, w_done}, {29'd0, exp_iwd});
  endtask

  initial begin
    reset = 1'b0; memdone = 1'b1; memrdata = '0;
    i_adr = '0; i_en = 0; d_adr = '0; d_wdata = '0; d_byteen = '0; d_rwb = 1; d_en = 0;
    w_adr = '0; w_wdata = '0; w_byteen = '0; w_en = 0;
    #12;
    chk("rst_memen", {31'd0, memen}, 32'd0);
    chk("rst_memadr", {2'd0, memadr}, 32'd0);
    chk("rst_memwdata", memwdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rwb_be", {27'd0, memrwb, membyteen}, 32'd0);
    chk_dones("rst_dones", 3'b000);
    tick();
    reset = 1'b1;
    tick();
    chk("idle_memen", {31'd0, memen}, 32'd0);

    // Single d write, memdone tied high.
    d_adr = 30'h0; d_wdata = 32'hDEADBEEF; d_byteen = 4'hF; d_rwb = 0; d_en = 1;
    tick();
    chk("dw_memen", {31'd0, memen}, 32'd1);
    chk("dw_memadr", {2'd0, memadr}, 32'd0);
    chk("dw_memwdata", memwdata, 32'hDEADBEEF);
    chk("dw_rwb_be", {27'd0, memrwb, membyteen}, 32'h0F);
    chk_dones("dw_nodone", 3'b000);
    tick();
    chk_dones("dw_done", 3'b010);
    chk("dw_memen_off", {31'd0, memen}, 32'd0);
    d_en = 0;
    tick();
    chk_dones("dw_done_1cyc", 3'b000);
    chk("dw_no_regrant", {31'd0, memen}, 32'd0);
    tick();
    chk("dw_still_idle", {31'd0, memen}, 32'd0);

    // Simultaneous i and d read.
    i_adr = 30'h04AD; i_en = 1; d_adr = 30'h0; d_rwb = 1; d_en = 1; memrdata = 32'h11111111;
    tick();
`ifdef MEMARB_RR_EN
    chk("id_first_adr", {2'd0, memadr}, 32'h04AD);
`else
    chk("id_first_adr", {2'd0, memadr}, 32'h0);
`endif
    chk("id_first_rwb_be", {27'd0, memrwb, membyteen}, 32'h1F);
    tick();
`ifdef MEMARB_RR_EN
    chk_dones("id_first_done", 3'b100);
    i_en = 0;
`else
    chk_dones("id_first_done", 3'b010);
    d_en = 0;
`endif
    chk("id_first_rdata", rdata, 32'h11111111);
    memrdata = 32'h22222222;
    tick();
    tick();
`ifdef MEMARB_RR_EN
    chk("id_second_adr", {2'd0, memadr}, 32'h0);
`else
    chk("id_second_adr", {2'd0, memadr}, 32'h04AD);
`endif
    chk("id_second_memen", {31'd0, memen}, 32'd1);
    tick();
`ifdef MEMARB_RR_EN
    chk_dones("id_second_done", 3'b010);
`else
    chk_dones("id_second_done", 3'b100);
`endif
    chk("id_second_rdata", rdata, 32'h22222222);
    i_en = 0; d_en = 0;
    tick();

    // Hazard: pending write to the same address as a d read.
    w_adr = 30'h00AD; w_wdata = 32'h00000100; w_byteen = 4'hF; w_en = 1;
    d_adr = 30'h00AD; d_rwb = 1; d_en = 1; memrdata = 32'h00000100;
    tick();
    chk("hz_w_adr", {2'd0, memadr}, 32'h00AD);
    chk("hz_w_wdata", memwdata, 32'h00000100);
    chk("hz_w_rwb", {31'd0, memrwb}, 32'd0);
    tick();
    chk_dones("hz_w_done", 3'b001);
    w_en = 0;
    tick();
    tick();
    chk("hz_d_rwb", {31'd0, memrwb}, 32'd1);
    tick();
    chk_dones("hz_d_done", 3'b010);
    chk("hz_rdata", rdata, 32'h00000100);
    d_en = 0;
    tick();

    // Slow memory: memdone low for 5 sampled edges.
    memdone = 0; i_adr = 30'h123; i_en = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("slow_memen", {31'd0, memen}, 32'd1);
      chk("slow_memadr", {2'd0, memadr}, 32'h123);
      chk_dones("slow_nodone", 3'b000);
      if (k == 4) memdone = 1;
      tick();
    end
    chk_dones("slow_done", 3'b100);
    chk("slow_memen_off", {31'd0, memen}, 32'd0);
    i_en = 0;
    tick();

    // Reset in the middle of MEM.
    memdone = 0; d_adr = 30'h55; d_wdata = 32'hA5A5A5A5; d_byteen = 4'h3; d_rwb = 0; d_en = 1;
    tick();
    chk("rm_memen_on", {31'd0, memen}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rm_memen_async", {31'd0, memen}, 32'd0);
    chk("rm_memadr_async", {2'd0, memadr}, 32'd0);
    d_en = 0; memdone = 1;
    tick();
    chk_dones("rm_nodone", 3'b000);
    reset = 1'b1;
    tick();
    chk_dones("rm_nodone2", 3'b000);
    w_adr = 30'h77; w_wdata = 32'h12345678; w_byteen = 4'h5; w_en = 1;
    tick();
    chk("rm_new_adr", {2'd0, memadr}, 32'h77);
    chk("rm_new_be", {28'd0, membyteen}, 32'h5);
    tick();
    chk_dones("rm_new_done", 3'b001);
    w_en = 0;
    tick();
    chk_dones("rm_done_1cyc", 3'b000);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
